// File: rtl/mcpu_pkg.sv
// Shared encodings for the mcpu multicycle controller: FSM states, ALU operation
// codes, instruction opcode/funct values and datapath mux-select codes.
package mcpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_LW    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_XOR = 4'd3,
        ALU_NOR = 4'd4,
        ALU_SRL = 4'd5,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_SLL = 4'd8
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS    = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [2:0] SRCB_RT      = 3'd0;
    localparam logic [2:0] SRCB_FOUR    = 3'd1;
    localparam logic [2:0] SRCB_SEXT    = 3'd2;
    localparam logic [2:0] SRCB_SEXT_SH = 3'd3;
    localparam logic [2:0] SRCB_ZEXT    = 3'd4;

    localparam logic [2:0] PCS_ALU    = 3'd0;
    localparam logic [2:0] PCS_ALUOUT = 3'd1;
    localparam logic [2:0] PCS_JUMP   = 3'd2;
    localparam logic [2:0] PCS_RS     = 3'd3;
    localparam logic [2:0] PCS_TRAP   = 3'd4;

    // Instructions whose signed overflow is architecturally meaningful.
    function automatic logic is_ovf_op(input logic [5:0] op, input logic [5:0] fn);
        return ((op == OP_RTYPE) && ((fn == FN_ADD) || (fn == FN_SUB))) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// Combinational ALU-operation decoder: maps FSM state plus opcode/funct to the
// 4-bit ALU operation and flags whether an R-type funct is supported.
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output alu_op_t    o_alu_op,
    output logic       o_funct_legal
);

    alu_op_t w_r_op;

    always_comb begin
        w_r_op        = ALU_AND;
        o_funct_legal = 1'b1;
        case (i_funct)
            FN_ADD:  w_r_op = ALU_ADD;
            FN_SUB:  w_r_op = ALU_SUB;
            FN_AND:  w_r_op = ALU_AND;
            FN_OR:   w_r_op = ALU_OR;
            FN_XOR:  w_r_op = ALU_XOR;
            FN_NOR:  w_r_op = ALU_NOR;
            FN_SLT:  w_r_op = ALU_SLT;
            FN_SLL:  w_r_op = ALU_SLL;
            FN_SRL:  w_r_op = ALU_SRL;
            default: o_funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        o_alu_op = ALU_AND;
        case (i_state)
            S_FETCH, S_DECODE, S_MEM_ADDR: o_alu_op = ALU_ADD;
            S_EXEC_R:                      o_alu_op = w_r_op;
            S_BRANCH:                      o_alu_op = ALU_SUB;
            S_EXEC_I: begin
                case (i_opcode)
                    OP_SLTI: o_alu_op = ALU_SLT;
                    OP_ANDI: o_alu_op = ALU_AND;
                    OP_ORI:  o_alu_op = ALU_OR;
                    OP_XORI: o_alu_op = ALU_XOR;
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            default: o_alu_op = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multicycle control FSM for the mcpu datapath (Moore-decoded controls).
// Optional overflow trap on add/sub/addi write-back: define MCPU_OVF_TRAP_EN.
module mcpu_ctrl
    import mcpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [2:0] pc_source,
    output logic [3:0] alu_operation,
    output logic       illegal_inst,
    output logic       bus_error,
`ifdef MCPU_OVF_TRAP_EN
    output logic       ovf_trap,
`endif
    output logic [3:0] state
);

    localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wait_cnt;
    logic            w_waiting;
    logic            w_timeout;
    logic            w_illegal;
    alu_op_t         w_alu_op;
    logic            w_funct_legal;
    logic            w_is_shift;

`ifdef MCPU_OVF_TRAP_EN
    logic            r_ovf;
    logic            w_trap;
    assign w_trap = r_ovf && is_ovf_op(opcode, funct)
                    && ((r_state == S_WB_R) || (r_state == S_WB_I));
`else
    logic            w_unused_ovf;
    assign w_unused_ovf = overflow;
`endif

    mcpu_alu_dec u_alu_dec (
        .i_state       (r_state),
        .i_opcode      (opcode),
        .i_funct       (funct),
        .o_alu_op      (w_alu_op),
        .o_funct_legal (w_funct_legal)
    );

    assign state      = r_state;
    assign w_is_shift = (w_alu_op == ALU_SLL) || (w_alu_op == ALU_SRL);
    assign w_waiting  = ((r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR))
                        && !mem_ready;
    // The counter holds completed wait cycles, so the error fires on the next one.
    assign w_timeout  = (MEM_TIMEOUT != 0) && w_waiting && (r_wait_cnt == CW'(MEM_TIMEOUT));

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: w_next = (funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_J:     w_next = S_JUMP;
                    OP_JAL:   w_next = S_JAL;
                    OP_BEQ, OP_BNE:                             w_next = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: w_next = S_EXEC_I;
                    OP_LW, OP_SW:                               w_next = S_MEM_ADDR;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                if (w_funct_legal) begin
                    w_next = S_WB_R;
                end else begin
                    w_next    = S_FETCH;
                    w_illegal = 1'b1;
                end
            end
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) w_next = S_WB_LW;
            S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_FETCH;
    end

    // Everything is forced low while rst is high so an aborted access issues no write.
    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = RDST_RT;
        mem_to_reg    = M2R_ALU;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RT;
        pc_source     = PCS_ALU;
        alu_operation = '0;
        illegal_inst  = 1'b0;
        bus_error     = 1'b0;
`ifdef MCPU_OVF_TRAP_EN
        ovf_trap      = 1'b0;
`endif
        if (!rst) begin
            alu_operation = w_alu_op;
            illegal_inst  = w_illegal;
            bus_error     = w_timeout;
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = SRCB_SEXT_SH;
                S_EXEC_R: alu_src_a = w_is_shift ? SRCA_SHAMT : SRCA_RS;
                S_EXEC_I: begin
                    alu_src_a = SRCA_RS;
                    alu_src_b = ((opcode == OP_ADDI) || (opcode == OP_SLTI)) ? SRCB_SEXT : SRCB_ZEXT;
                end
                S_MEM_ADDR: begin
                    alu_src_a = SRCA_RS;
                    alu_src_b = SRCB_SEXT;
                end
                S_MEM_RD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEM_WR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = RDST_RD;
                end
                S_WB_I: reg_write = 1'b1;
                S_WB_LW: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                end
                S_BRANCH: begin
                    alu_src_a = SRCA_RS;
                    pc_source = PCS_ALUOUT;
                    pc_write  = (opcode == OP_BNE) ? !zero : zero;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCS_JUMP;
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    pc_source  = PCS_JUMP;
                    reg_write  = 1'b1;
                    reg_dst    = RDST_RA;
                    mem_to_reg = M2R_PC;
                end
                S_JR: begin
                    pc_write  = 1'b1;
                    pc_source = PCS_RS;
                end
                default: ;
            endcase
`ifdef MCPU_OVF_TRAP_EN
            if (w_trap) begin
                reg_write = 1'b0;
                pc_write  = 1'b1;
                pc_source = PCS_TRAP;
                ovf_trap  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
`ifdef MCPU_OVF_TRAP_EN
            r_ovf      <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || w_timeout) begin
                r_wait_cnt <= '0;
            end else if ((MEM_TIMEOUT != 0) && w_waiting) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
`ifdef MCPU_OVF_TRAP_EN
            if ((r_state == S_EXEC_R) || (r_state == S_EXEC_I)) r_ovf <= overflow;
`endif
        end
    end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Self-checking bench for mcpu_ctrl: each instruction is expanded into its expected
// per-cycle control trace, then replayed against the DUT (directed + random).
module tb_mcpu_ctrl;

    localparam int unsigned TMO = 4;
`ifdef MCPU_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] st;
        logic       irw, pcw, iord, mrd, mwr, rw;
        logic [1:0] rdst, m2r, sa;
        logic [2:0] sb, pcs;
        logic [3:0] aop;
        logic       ill, berr, trap;
    } obs_t;

    typedef struct {
        obs_t  exp;
        logic  rdy;
        logic  ovf;
        string tag;
    } step_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, overflow, mem_ready;
    logic       ir_write, pc_write, iord, mem_read, mem_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a;
    logic [2:0] alu_src_b, pc_source;
    logic [3:0] alu_operation, state;
    logic       illegal_inst, bus_error, w_trap;
    obs_t       w_obs;

    int n_chk = 0;
    int n_pass = 0;
    step_t q[$];

    always #5 clk = ~clk;

    mcpu_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .overflow(overflow), .mem_ready(mem_ready), .ir_write(ir_write),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_operation(alu_operation), .illegal_inst(illegal_inst), .bus_error(bus_error),
`ifdef MCPU_OVF_TRAP_EN
        .ovf_trap(w_trap),
`endif
        .state(state)
    );

`ifndef MCPU_OVF_TRAP_EN
    assign w_trap = 1'b0;
`endif

    assign w_obs = {state, ir_write, pc_write, iord, mem_read, mem_write, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_operation,
                    illegal_inst, bus_error, w_trap};

    function automatic obs_t blank(input logic [3:0] st);
        obs_t o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic [3:0] r_aop(input logic [5:0] fn, output logic ok);
        ok = 1'b1;
        case (fn)
            6'h20: return 4'd2;
            6'h22: return 4'd6;
            6'h24: return 4'd0;
            6'h25: return 4'd1;
            6'h26: return 4'd3;
            6'h27: return 4'd4;
            6'h2A: return 4'd7;
            6'h00: return 4'd8;
            6'h02: return 4'd5;
            default: begin
                ok = 1'b0;
                return 4'd0;
            end
        endcase
    endfunction

    function automatic logic [3:0] i_aop(input logic [5:0] op);
        case (op)
            6'h0A:   return 4'd7;
            6'h0C:   return 4'd0;
            6'h0D:   return 4'd1;
            6'h0E:   return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic obs_t trap_fix(input obs_t e, input logic [5:0] op, input logic [5:0] fn,
                                      input logic ovf);
        obs_t o = e;
        if (TRAP_EN && ovf && (((op == 6'h00) && ((fn == 6'h20) || (fn == 6'h22))) || (op == 6'h08))) begin
            o.rw   = 1'b0;
            o.pcw  = 1'b1;
            o.pcs  = 3'd4;
            o.trap = 1'b1;
        end
        return o;
    endfunction

    task automatic push(input obs_t e, input logic rdy, input logic ovf, input string tag);
        step_t s;
        s.exp = e;
        s.rdy = rdy;
        s.ovf = ovf;
        s.tag = tag;
        q.push_back(s);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Memory handshake phase: lat low cycles before ready; timeout if lat exceeds TMO.
    task automatic mem_phase(input obs_t e, input int unsigned lat, input string tag, output logic ok);
        obs_t w = e;
        for (int unsigned i = 0; (i < lat) && (i < TMO); i++) push(w, 1'b0, rb(), tag);
        if (lat > TMO) begin
            w.berr = 1'b1;
            push(w, 1'b0, rb(), tag);
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ovf,
                         input int unsigned lf, input int unsigned lm, input string tag);
        obs_t e;
        logic ok;
        logic [3:0] aop;
        q.delete();
        e = blank(4'd0); e.mrd = 1'b1; e.sb = 3'd1; e.aop = 4'd2;
        mem_phase(e, lf, tag, ok);
        if (!ok) return;
        e.irw = 1'b1; e.pcw = 1'b1;
        push(e, 1'b1, rb(), tag);
        e = blank(4'd1); e.sb = 3'd3; e.aop = 4'd2;
        case (op)
            6'h00: begin
                push(e, rb(), rb(), tag);
                if (fn == 6'h08) begin
                    e = blank(4'd13); e.pcw = 1'b1; e.pcs = 3'd3;
                    push(e, rb(), rb(), tag);
                end else begin
                    aop = r_aop(fn, ok);
                    e = blank(4'd2); e.aop = aop; e.ill = !ok;
                    e.sa = (ok && ((fn == 6'h00) || (fn == 6'h02))) ? 2'd2 : 2'd1;
                    push(e, rb(), ovf, tag);
                    if (ok) begin
                        e = blank(4'd7); e.rw = 1'b1; e.rdst = 2'd1;
                        push(trap_fix(e, op, fn, ovf), rb(), rb(), tag);
                    end
                end
            end
            6'h02: begin
                push(e, rb(), rb(), tag);
                e = blank(4'd11); e.pcw = 1'b1; e.pcs = 3'd2;
                push(e, rb(), rb(), tag);
            end
            6'h03: begin
                push(e, rb(), rb(), tag);
                e = blank(4'd12); e.pcw = 1'b1; e.pcs = 3'd2; e.rw = 1'b1; e.rdst = 2'd2; e.m2r = 2'd2;
                push(e, rb(), rb(), tag);
            end
            6'h04, 6'h05: begin
                push(e, rb(), rb(), tag);
                e = blank(4'd10); e.sa = 2'd1; e.aop = 4'd6; e.pcs = 3'd1;
                e.pcw = (op == 6'h04) ? z : !z;
                push(e, rb(), rb(), tag);
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                push(e, rb(), rb(), tag);
                e = blank(4'd3); e.sa = 2'd1; e.aop = i_aop(op);
                e.sb = ((op == 6'h08) || (op == 6'h0A)) ? 3'd2 : 3'd4;
                push(e, rb(), ovf, tag);
                e = blank(4'd8); e.rw = 1'b1;
                push(trap_fix(e, op, fn, ovf), rb(), rb(), tag);
            end
            6'h23, 6'h2B: begin
                push(e, rb(), rb(), tag);
                e = blank(4'd4); e.sa = 2'd1; e.sb = 3'd2; e.aop = 4'd2;
                push(e, rb(), rb(), tag);
                if (op == 6'h23) begin
                    e = blank(4'd5); e.mrd = 1'b1;
                end else begin
                    e = blank(4'd6); e.mwr = 1'b1;
                end
                e.iord = 1'b1;
                mem_phase(e, lm, tag, ok);
                if (!ok) return;
                push(e, 1'b1, rb(), tag);
                if (op == 6'h23) begin
                    e = blank(4'd9); e.rw = 1'b1; e.m2r = 2'd1;
                    push(e, rb(), rb(), tag);
                end
            end
            default: begin
                e.ill = 1'b1;
                push(e, rb(), rb(), tag);
            end
        endcase
    endtask

    task automatic check(input string tag, input int k, input obs_t e);
        n_chk++;
        assert (w_obs === e) n_pass++;
        else $error("FAIL %s step %0d: got %h expected %h", tag, k, w_obs, e);
    endtask

    task automatic run_q();
        int k = 0;
        while (q.size() != 0) begin
            step_t s;
            s = q.pop_front();
            mem_ready = s.rdy;
            overflow  = s.ovf;
            @(negedge clk);
            check(s.tag, k, s.exp);
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ovf,
                            input int unsigned lf, input int unsigned lm, input string tag);
        build(op, fn, z, ovf, lf, lm, tag);
        opcode = op;
        funct  = fn;
        zero   = z;
        run_q();
    endtask

    localparam logic [5:0] OPS [12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                        6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B};
    localparam logic [5:0] FNS [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                                        6'h2A, 6'h00, 6'h02, 6'h08};

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset", 0, blank(4'd0));
        @(posedge clk); #1;
        rst = 1'b0;

        do_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, 0, "add");
        do_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, 3, "lw_wait3");
        do_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, TMO, "lw_edge");
        do_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, TMO + 1, "lw_tmo");
        do_instr(6'h2B, 6'h00, 1'b0, 1'b0, 1, TMO + 3, "sw_tmo");
        do_instr(6'h00, 6'h20, 1'b0, 1'b0, TMO + 2, 0, "fetch_tmo");
        do_instr(6'h00, 6'h20, 1'b0, 1'b0, TMO, 0, "fetch_edge");
        do_instr(6'h04, 6'h00, 1'b1, 1'b0, 0, 0, "beq_z1");
        do_instr(6'h05, 6'h00, 1'b1, 1'b0, 0, 0, "bne_z1");
        do_instr(6'h04, 6'h00, 1'b0, 1'b0, 0, 0, "beq_z0");
        do_instr(6'h05, 6'h00, 1'b0, 1'b0, 0, 0, "bne_z0");
        do_instr(6'h00, 6'h00, 1'b0, 1'b0, 0, 0, "sll");
        do_instr(6'h00, 6'h02, 1'b0, 1'b0, 0, 0, "srl");
        do_instr(6'h3F, 6'h00, 1'b0, 1'b0, 0, 0, "illegal_op");
        do_instr(6'h00, 6'h01, 1'b0, 1'b0, 0, 0, "illegal_fn");
        do_instr(6'h00, 6'h20, 1'b0, 1'b1, 0, 0, "add_ovf");
        do_instr(6'h08, 6'h20, 1'b0, 1'b1, 0, 0, "addi_ovf");
        do_instr(6'h0D, 6'h00, 1'b0, 1'b1, 0, 0, "ori_ovf");
        do_instr(6'h02, 6'h00, 1'b0, 1'b0, 0, 0, "j");
        do_instr(6'h03, 6'h00, 1'b0, 1'b0, 0, 0, "jal");
        do_instr(6'h00, 6'h08, 1'b0, 1'b0, 0, 0, "jr");
        do_instr(6'h2B, 6'h00, 1'b0, 1'b0, 0, 2, "sw");

        // Abort a pending store with rst: no write strobe in the reset cycle.
        build(6'h2B, 6'h00, 1'b0, 1'b0, 0, 2, "sw_rst");
        while (q.size() > 4) void'(q.pop_back());
        opcode = 6'h2B; funct = '0; zero = 1'b0;
        run_q();
        rst = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        check("rst_mid_wr", 0, blank(4'd6));
        @(posedge clk); #1;
        rst = 1'b0;
        do_instr(6'h23, 6'h00, 1'b0, 1'b0, TMO, TMO, "post_rst_lw");

        for (int n = 0; n < 250; n++) begin
            logic [5:0] op, fn;
            int unsigned lf, lm;
            int unsigned sel;
            sel = $urandom_range(0, 13);
            op  = (sel < 12) ? OPS[sel] : 6'($urandom_range(0, 63));
            sel = $urandom_range(0, 11);
            fn  = (sel < 10) ? FNS[sel] : 6'($urandom_range(0, 63));
            lf  = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, 2);
            lm  = ($urandom_range(0, 5) == 0) ? TMO + 1 : $urandom_range(0, TMO);
            do_instr(op, fn, rb(), rb(), lf, lm, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
Multicycle control FSM for the mcpu datapath. Sequences instruction fetch, decode, execute, memory and write-back, and drives the register-file, memory, PC and operand-mux enables, plus the 4-bit ALU operation code. Sits beside the datapath; the datapath feeds back opcode, funct, ALU zero/overflow and memory ready.

Parameters:
MEM_TIMEOUT, 255, number of consecutive wait cycles on mem_ready before bus_error is raised; 0 disables the timeout

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
overflow  in  1  ALU signed-overflow flag
mem_ready  in  1  memory has completed the current read or write this cycle
ir_write  out  1  load IR (and MDR) from memory
pc_write  out  1  unconditional PC load
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register-file write
reg_dst  out  2  destination select: 0 = rt, 1 = rd, 2 = $31
mem_to_reg  out  2  write-data select: 0 = ALUOut, 1 = MDR, 2 = PC
alu_src_a  out  2  A-operand select: 0 = PC, 1 = rs, 2 = shamt (zero-extended)
alu_src_b  out  3  B-operand select: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2, 4 = zero-extended imm
pc_source  out  3  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs, 4 = trap vector
alu_operation  out  4  0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SRL (B>>A), 6 SUB, 7 SLT, 8 SLL (B<<A)
illegal_inst  out  1  one-cycle pulse when an unsupported opcode/funct is decoded
bus_error  out  1  one-cycle pulse on memory timeout
state  out  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_LW=9, BRANCH=10, JUMP=11, JAL=12, JR=13.
- Reset: state=FETCH and the timeout counter is cleared. An asserted rst aborts any state, including a pending memory wait, with no write issued in that cycle.
- Outputs are decoded from state (Moore). The only exceptions are pc_write, ir_write and branch qualification, which also depend on mem_ready/zero. Any output not listed for a state is 0, and all selects default to 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_operation=ADD, pc_source=0. ir_write and pc_write equal mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_operation=ADD (branch target into ALUOut). Next state by opcode:
  - 0x00: EXEC_R, or JR if funct=0x08.
  - 0x02: JUMP. 0x03: JAL. 0x04/0x05: BRANCH.
  - 0x08/0x0A/0x0C/0x0D/0x0E: EXEC_I.
  - 0x23/0x2B: MEM_ADDR.
  - Anything else: FETCH with illegal_inst=1.
- EXEC_R: alu_src_b=0. alu_src_a=2 for sll/srl, otherwise 1.
  - funct map: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x00 SLL, 0x02 SRL.
  - Unknown funct: FETCH with illegal_inst=1. Otherwise go to WB_R.
- EXEC_I: alu_src_a=1. addi/slti use alu_src_b=2 with ADD/SLT; andi/ori/xori use alu_src_b=4 with AND/OR/XOR. Next state WB_I.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1, mem_read=1. Wait for mem_ready, then WB_LW.
- MEM_WR: iord=1, mem_write=1. Wait for mem_ready, then FETCH.
- WB_R: reg_write=1, reg_dst=1. WB_I: reg_write=1, reg_dst=0. WB_LW: reg_write=1, mem_to_reg=1. All return to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_source=1. pc_write = zero for beq (0x04), !zero for bne (0x05). Next FETCH.
- JUMP: pc_write=1, pc_source=2.
- JAL: pc_write=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2. The PC already holds PC+4, so $31 receives PC+4.
- JR: pc_write=1, pc_source=3.
- Memory timeout: the counter increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0 and clears on any state change. When it reaches MEM_TIMEOUT (nonzero), bus_error=1 for one cycle and the next state is FETCH. No PC or register update occurs. If mem_ready arrives in that same cycle, mem_ready wins and no error is raised.

Optional Feature:
MCPU_OVF_TRAP_EN
- Defined: in WB_R/WB_I for add, sub or addi, a registered overflow from the execute cycle suppresses reg_write. In that cycle pc_write=1 and pc_source=4 (trap vector), with a one-cycle ovf_trap output pulse (extra 1-bit port).
- Undefined: overflow is ignored, the result is written back, pc_source never equals 4, and there is no ovf_trap port.

Decomposition:
- mcpu_pkg holds the state codes, ALU operation codes (0–8), opcode/funct constants and mux-select encodings.
- One combinational sub-module, mcpu_alu_dec, maps (state, opcode, funct) to alu_operation and the funct-legal flag.

Test Plan:
- add $3,$1,$2 (funct 0x20), mem_ready always 1: states 0→1→2→7→0 in 4 cycles. alu_operation=2 in EXEC_R; reg_write=1, reg_dst=1 in WB_R.
- lw with mem_ready held low 3 cycles in MEM_RD: state stays 5 for 4 cycles, then WB_LW with mem_to_reg=1. With MEM_TIMEOUT=2, bus_error pulses once and the FSM returns to FETCH.
- beq with zero=1: pc_write=1, pc_source=1. bne with zero=1: pc_write=0. Both reach FETCH next.
- sll (funct 0x00): alu_src_a=2, alu_src_b=0, alu_operation=8. srl: alu_operation=5.
- Opcode 0x3F: illegal_inst=1 for one cycle in DECODE, next state FETCH, no writes. rst asserted mid-MEM_WR: next state FETCH, mem_write=0.
- With MCPU_OVF_TRAP_EN, add and overflow=1: reg_write=0, pc_source=4, ovf_trap=1. Without the macro, reg_write=1.
